// File: rtl/anim_frame_seq.sv
// Frame sequencer for the 7-segment animation decoders: picks which of FRAMES frames is shown
// and when, with a programmable period, play/pause/stop control and four playback modes.
module anim_frame_seq #(
    parameter int unsigned FRAMES = 32,
    parameter int unsigned DIV_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [4:0]       frame,
    output logic             frame_tick,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] LastFrame = 5'(FRAMES - 1);
    localparam logic [1:0] ModeFwd   = 2'b00;
    localparam logic [1:0] ModeRev   = 2'b01;
    localparam logic [1:0] ModePing  = 2'b10;
    localparam logic [1:0] ModeOnce  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e           state_q, state_d;
    logic [4:0]       frame_q, frame_d;
    logic             dir_q, dir_d;  // 1 = counting up
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;

    logic [4:0]       nxt_frame;
    logic             nxt_dir;
    logic             finish;

    // Frame that the next advance would show, given the latched mode.
    always_comb begin
        nxt_frame = frame_q;
        nxt_dir   = dir_q;
        finish    = 1'b0;
        unique case (mode_q)
            ModeFwd: nxt_frame = (frame_q == LastFrame) ? 5'd0 : frame_q + 5'd1;
            ModeRev: nxt_frame = (frame_q == 5'd0) ? LastFrame : frame_q - 5'd1;
            ModePing: begin
                if (LastFrame == 5'd0) begin
                    nxt_frame = 5'd0;
                end else if (dir_q) begin
                    if (frame_q == LastFrame) begin
                        nxt_frame = LastFrame - 5'd1;
                        nxt_dir   = 1'b0;
                    end else begin
                        nxt_frame = frame_q + 5'd1;
                    end
                end else begin
                    if (frame_q == 5'd0) begin
                        nxt_frame = 5'd1;
                        nxt_dir   = 1'b1;
                    end else begin
                        nxt_frame = frame_q - 5'd1;
                    end
                end
            end
            ModeOnce: begin
                if (frame_q == LastFrame) begin
                    finish = 1'b1;
                end else begin
                    nxt_frame = frame_q + 5'd1;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        div_d   = div_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            frame_d = 5'd0;
            dir_d   = 1'b1;
            presc_d = '0;
        end else if (start) begin
            mode_d  = mode;
            div_d   = (div == '0) ? DIV_W'(1) : div;
            frame_d = (mode == ModeRev) ? LastFrame : 5'd0;
            dir_d   = 1'b1;
            presc_d = '0;
            state_d = pause ? StHold : StRun;
        end else begin
            unique case (state_q)
                StIdle, StDone: presc_d = '0;
                StHold: begin
                    if (!pause) state_d = StRun;
                end
                StRun: begin
                    // An advance coinciding with pause is deferred: the count stays at terminal.
                    if (pause) begin
                        state_d = StHold;
                    end else if (presc_q == div_q - DIV_W'(1)) begin
                        presc_d = '0;
                        if (finish) begin
                            state_d = StDone;
                        end else begin
                            frame_d = nxt_frame;
                            dir_d   = nxt_dir;
                            tick_d  = (nxt_frame != frame_q);
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            frame_q <= 5'd0;
            dir_q   <= 1'b1;
            presc_q <= '0;
            div_q   <= DIV_W'(1);
            mode_q  <= ModeFwd;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign frame      = frame_q;
    assign frame_tick = tick_q;
    assign busy       = (state_q == StRun) || (state_q == StHold);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_anim_frame_seq.sv
// Scoreboard bench for anim_frame_seq: expected frames and tick spacing are queued when playback
// is started and checked as each frame_tick appears.
module tb_anim_frame_seq;

    logic        clk = 1'b0;
    logic        rst, start, stop, pause;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [4:0]  frame;
    logic        frame_tick, busy, done;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [4:0] frame;
        int         gap;
    } exp_t;

    exp_t sb[$];

    anim_frame_seq #(.FRAMES(32), .DIV_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .div        (div),
        .frame      (frame),
        .frame_tick (frame_tick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] f, input int g);
        exp_t e;
        e.frame = f;
        e.gap   = g;
        sb.push_back(e);
    endtask

    // Pops each expectation, waits (bounded) for the next tick and checks value and spacing.
    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            bit   got;
            e   = sb.pop_front();
            n   = 0;
            got = 1'b0;
            while (!got && n < e.gap * 2 + 8) begin
                step();
                n++;
                if (frame_tick) got = 1'b1;
            end
            if (!got) begin
                check_eq("tick_timeout", 32'd0, 32'd1);
            end else begin
                check_eq("frame", 32'(frame), 32'(e.frame));
                check_eq("gap", 32'(n), 32'(e.gap));
            end
        end
    endtask

    task automatic start_pb(input logic [1:0] m, input logic [23:0] d, input logic [4:0] f0);
        mode  = m;
        div   = d;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_frame", 32'(frame), 32'(f0));
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_tick", 32'(frame_tick), 32'd0);
        check_eq("start_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        mode  = 2'b00;
        div   = 24'd0;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_frame", 32'(frame), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_tick", 32'(frame_tick), 32'd0);

        // Forward loop, 3 cycles per frame, through the wrap.
        start_pb(2'b00, 24'd3, 5'd0);
        for (int i = 1; i < 32; i++) push(5'(i), 3);
        push(5'd0, 3);
        push(5'd1, 3);
        drain();

        // Ping-pong at full rate: endpoints shown once.
        start_pb(2'b10, 24'd1, 5'd0);
        for (int i = 1; i < 32; i++) push(5'(i), 1);
        for (int i = 30; i >= 0; i--) push(5'(i), 1);
        push(5'd1, 1);
        push(5'd2, 1);
        drain();

        // One-shot, then restart.
        start_pb(2'b11, 24'd2, 5'd0);
        for (int i = 1; i < 32; i++) push(5'(i), 2);
        drain();
        step();
        check_eq("once_done_early", 32'(done), 32'd0);
        step();
        check_eq("once_done", 32'(done), 32'd1);
        check_eq("once_busy", 32'(busy), 32'd0);
        check_eq("once_frame", 32'(frame), 32'd31);
        check_eq("once_tick", 32'(frame_tick), 32'd0);
        step();
        check_eq("once_hold", 32'(frame), 32'd31);
        start_pb(2'b11, 24'd2, 5'd0);

        // Reverse with a 10-cycle pause mid-frame.
        start_pb(2'b01, 24'd4, 5'd31);
        push(5'd30, 4);
        drain();
        step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("pause_frame", 32'(frame), 32'd30);
        check_eq("pause_tick", 32'(frame_tick), 32'd0);
        check_eq("pause_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        push(5'd29, 4);
        push(5'd28, 4);
        drain();

        // Stop wins over a simultaneous start.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("stop_frame", 32'(frame), 32'd0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_tick", 32'(frame_tick), 32'd0);
        check_eq("stop_done", 32'(done), 32'd0);

        // div=0 behaves as div=1; reset lands on the edge a tick was due.
        start_pb(2'b00, 24'd0, 5'd0);
        for (int i = 1; i <= 17; i++) push(5'(i), 1);
        drain();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst_frame", 32'(frame), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_tick", 32'(frame_tick), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/anim_frame_seq.md
# anim_frame_seq

Frame sequencer that generates the 5-bit animation frame index consumed by the per-digit 7-segment pattern decoders. The decoders map frame 0–31 to a segment pattern; this block decides which frame is shown and when. It provides a programmable frame period, play/pause/stop control, and four playback modes. All digit decoders share its `frame` output so every digit stays in lockstep.

## Interface

Parameters:
- `FRAMES`, default 32: number of frames; `frame` counts 0..FRAMES-1, with FRAMES ≤ 32.
- `DIV_W`, default 24: width of the frame-period divisor.

Ports:
- `clk`  in  1: the single system clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that latches `mode`/`div` and begins playback.
- `stop`  in  1: one-cycle pulse that aborts playback and returns to idle.
- `pause`  in  1: level; while high, playback freezes.
- `mode`  in  2: 00 loop forward, 01 loop reverse, 10 ping-pong, 11 one-shot forward.
- `div`  in  DIV_W: clock cycles per frame; a value of 0 is treated as 1.
- `frame`  out  5: current frame index, registered, driving the digit decoders.
- `frame_tick`  out  1: one-cycle pulse in the cycle `frame` takes a new value during playback.
- `busy`  out  1: high in RUN or HOLD.
- `done`  out  1: high in DONE (one-shot finished).

## Operation

- FSM states: IDLE, RUN, HOLD, DONE.
- Reset values: state IDLE, `frame`=0, `frame_tick`=0, `busy`=0, `done`=0, prescaler=0, direction=up.
- Latched copies: `mode_q` and `div_q` are captured on an accepted `start` and are ignored at all other times.
  - `div_q` is forced to 1 when `div`=0.
- Prescaler: counts 0..div_q-1 in RUN only.
  - The terminal count produces an advance and reloads the prescaler to 0.
  - The prescaler is frozen in HOLD and cleared in IDLE and DONE.
- Start frame on accepted `start`:
  - FRAMES-1 for mode 01.
  - 0 for all other modes.
  - Direction is set to up.
- Advance rules:
  - 00: frame+1, wrapping FRAMES-1 → 0.
  - 01: frame-1, wrapping 0 → FRAMES-1.
  - 10: moves in the current direction.
    - At FRAMES-1 the direction flips to down and the next frame is FRAMES-2.
    - At 0 the direction flips to up and the next frame is 1.
    - Endpoints are never shown twice in a row.
    - When FRAMES=1, frame stays 0.
  - 11: frame+1 until FRAMES-1. The next advance after reaching FRAMES-1 enters DONE, with `frame` holding FRAMES-1 and no `frame_tick`.
- Transitions, in priority order (`rst` > `stop` > `start` > `pause` > advance):
  - `stop` from any state → IDLE, with `frame`=0 and direction up.
  - `start` from any state → playback restarts from the start frame.
    - Goes to RUN, or to HOLD if `pause` is high in the same cycle.
    - The prescaler is cleared.
  - RUN with `pause`=1 → HOLD.
  - HOLD with `pause`=0 → RUN, resuming with the preserved prescaler count.
  - DONE holds until `start` or `stop`.
- `pause` in IDLE or DONE has no effect.
- `frame` changes only on `start`, on `stop`, on an advance, or on reset.

## Timing

- Start latency: `start` sampled at edge N → at edge N+1, `frame` equals the start frame and `busy`=1.
  - No `frame_tick` is issued for this initial load.
- Frame period: the first advance occurs div_q cycles after entering RUN; every following advance is div_q cycles later.
  - div_q=1 advances every cycle.
- `frame_tick` is registered and high in exactly the cycle the new frame first appears.
- Pause: pause rising at edge N stops counting from edge N+1.
  - The number of RUN cycles between frames is always exactly div_q, so pause time is excluded.
  - An advance due at the same edge as pause assertion is suppressed and taken after resume.
- One-shot: `done` rises div_q cycles after frame FRAMES-1 appeared; `busy` falls in the same cycle.
- Stop/reset: take effect at the next edge regardless of prescaler phase. Mid-operation they clear `frame_tick` in that cycle.

## Test plan

- Reset, then `start` with mode=00, div=3 → `frame` runs 0,1,2…31,0, one value every 3 cycles; `frame_tick` once per change; `busy`=1.
- mode=10, div=1, FRAMES=32 → sequence …30,31,30…1,0,1…; no repeated endpoint; a period of 62 cycles.
- mode=11, div=2 → frame reaches 31, then 2 cycles later `done`=1 and `busy`=0 with frame held at 31; a second `start` restarts from 0 with `done`=0.
- mode=01, div=4, `pause` high for 10 cycles mid-frame → the frame holds, and the next decrement arrives after the remaining prescaler count; total RUN cycles per frame = 4.
- `start` and `stop` in the same cycle during RUN → IDLE with `frame`=0; `div`=0 start → advances every cycle.
- `rst` asserted mid-playback at frame 17 → next cycle: `frame`=0, `busy`=0, `done`=0, `frame_tick`=0.
